// File: rtl/hevc_nal_pkg.sv
// Shared types and constants for the HEVC Annex-B NAL unit parser.
package hevc_nal_pkg;

    typedef enum logic [2:0] {
        StSearch,
        StHdr0,
        StHdr1,
        StPayload,
        StFlush
    } nal_state_e;

    localparam logic [7:0] START_CODE_LSB = 8'h01;
    localparam logic [7:0] EP_BYTE        = 8'h03;

    localparam logic [5:0] NAL_VPS = 6'd32;
    localparam logic [5:0] NAL_SPS = 6'd33;
    localparam logic [5:0] NAL_PPS = 6'd34;
    localparam logic [5:0] NAL_AUD = 6'd35;

endpackage

// File: rtl/nal_unit_parser_if.sv
// Byte-stream input and RBSP/header output bundle of the NAL unit parser.
interface nal_unit_parser_if #(
    parameter int unsigned EP_CNT_W = 16
);
    logic [7:0]          din;
    logic                din_vld;
    logic                eos;
    logic                busy;
    logic [7:0]          rbsp_byte;
    logic                rbsp_vld;
    logic                nal_start;
    logic                hdr_vld;
    logic [5:0]          nal_type;
    logic [5:0]          layer_id;
    logic [2:0]          tid_plus1;
    logic                hdr_err;
    logic                nal_end;
    logic [EP_CNT_W-1:0] ep_cnt;

    // Bitstream loader side.
    modport master (
        output din, din_vld, eos,
        input  busy, rbsp_byte, rbsp_vld, nal_start, hdr_vld, nal_type, layer_id,
        input  tid_plus1, hdr_err, nal_end, ep_cnt
    );

    // Parser side.
    modport slave (
        input  din, din_vld, eos,
        output busy, rbsp_byte, rbsp_vld, nal_start, hdr_vld, nal_type, layer_id,
        output tid_plus1, hdr_err, nal_end, ep_cnt
    );
endinterface

// File: rtl/nal_ep_window.sv
// Zero-run tracking and 2-entry payload delay window. The delay lets trailing
// zeros that turn out to belong to a start code be discarded before emission.
module nal_ep_window (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] byte_i,
    input  logic       byte_vld_i,
    input  logic       drop_i,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic       discard_i,
    output logic [1:0] zcnt_o,
    output logic [1:0] cnt_o,
    output logic [7:0] emit_byte_o,
    output logic       emit_vld_o
);
    logic [1:0]      zcnt_q, zcnt_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [1:0][7:0] win_q, win_d;  // entry 0 is the oldest
    logic [7:0]      emit_byte_q, emit_byte_d;
    logic            emit_vld_q, emit_vld_d;

    // Next-state: zero-run counter and window shift/emit.
    always_comb begin
        zcnt_d      = zcnt_q;
        cnt_d       = cnt_q;
        win_d       = win_q;
        emit_byte_d = emit_byte_q;
        emit_vld_d  = 1'b0;

        if (byte_vld_i) begin
            if (drop_i || byte_i != 8'h00) begin
                zcnt_d = 2'd0;
            end else if (zcnt_q != 2'd2) begin
                zcnt_d = zcnt_q + 2'd1;
            end
        end

        if (discard_i) begin
            cnt_d = 2'd0;
        end else if (push_i) begin
            if (cnt_q == 2'd2) begin
                emit_byte_d = win_q[0];
                emit_vld_d  = 1'b1;
                win_d[0]    = win_q[1];
                win_d[1]    = byte_i;
            end else begin
                win_d[cnt_q[0]] = byte_i;
                cnt_d           = cnt_q + 2'd1;
            end
        end else if (pop_i && cnt_q != 2'd0) begin
            emit_byte_d = win_q[0];
            emit_vld_d  = 1'b1;
            win_d[0]    = win_q[1];
            cnt_d       = cnt_q - 2'd1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zcnt_q      <= 2'd0;
            cnt_q       <= 2'd0;
            win_q       <= '0;
            emit_byte_q <= 8'h00;
            emit_vld_q  <= 1'b0;
        end else begin
            zcnt_q      <= zcnt_d;
            cnt_q       <= cnt_d;
            win_q       <= win_d;
            emit_byte_q <= emit_byte_d;
            emit_vld_q  <= emit_vld_d;
        end
    end

    assign zcnt_o      = zcnt_q;
    assign cnt_o       = cnt_q;
    assign emit_byte_o = emit_byte_q;
    assign emit_vld_o  = emit_vld_q;
endmodule

// File: rtl/nal_unit_parser.sv
// HEVC Annex-B receiver: start-code detection, NAL header decode and
// emulation-prevention removal, emitting RBSP bytes and NAL framing pulses.
module nal_unit_parser
    import hevc_nal_pkg::*;
#(
    parameter int unsigned EP_CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    nal_unit_parser_if.slave bus
);
    nal_state_e          state_q, state_d;
    logic [7:0]          hdr0_q, hdr0_d;
    logic [5:0]          nal_type_q, nal_type_d;
    logic [5:0]          layer_id_q, layer_id_d;
    logic [2:0]          tid_q, tid_d;
    logic                hdr_err_q, hdr_err_d;
    logic                hdr_vld_q, hdr_vld_d;
    logic                nal_start_q, nal_start_d;
    logic                nal_end_q, nal_end_d;
    logic                busy_q, busy_d;
    logic [EP_CNT_W-1:0] ep_cnt_q, ep_cnt_d;

    logic       push, drop, pop, discard, start_code;
    logic [1:0] zcnt, win_cnt;

    nal_ep_window u_window (
        .clk         (clk),
        .rst_n       (rst_n),
        .byte_i      (bus.din),
        .byte_vld_i  (bus.din_vld && state_q != StFlush),
        .drop_i      (drop),
        .push_i      (push),
        .pop_i       (pop),
        .discard_i   (discard),
        .zcnt_o      (zcnt),
        .cnt_o       (win_cnt),
        .emit_byte_o (bus.rbsp_byte),
        .emit_vld_o  (bus.rbsp_vld)
    );

    assign start_code = bus.din_vld && (bus.din == START_CODE_LSB) && (zcnt == 2'd2) &&
                        (state_q != StFlush);

    // FSM next-state, header capture, window controls and pulse outputs.
    always_comb begin
        state_d     = state_q;
        hdr0_d      = hdr0_q;
        nal_type_d  = nal_type_q;
        layer_id_d  = layer_id_q;
        tid_d       = tid_q;
        hdr_err_d   = hdr_err_q;
        hdr_vld_d   = 1'b0;
        nal_start_d = 1'b0;
        nal_end_d   = 1'b0;
        ep_cnt_d    = ep_cnt_q;
        push        = 1'b0;
        drop        = 1'b0;
        pop         = 1'b0;
        discard     = 1'b0;

        if (start_code) begin
            // Window holds only start-code zeros at this point.
            nal_end_d   = (state_q == StPayload);
            discard     = 1'b1;
            nal_start_d = 1'b1;
            ep_cnt_d    = '0;
            state_d     = StHdr0;
        end else begin
            case (state_q)
                StSearch: ;
                StHdr0: begin
                    if (bus.din_vld) begin
                        hdr0_d  = bus.din;
                        state_d = StHdr1;
                    end
                end
                StHdr1: begin
                    if (bus.din_vld) begin
                        nal_type_d = hdr0_q[6:1];
                        layer_id_d = {hdr0_q[0], bus.din[7:3]};
                        tid_d      = bus.din[2:0];
                        hdr_err_d  = hdr0_q[7] | (bus.din[2:0] == 3'd0);
                        hdr_vld_d  = 1'b1;
                        discard    = 1'b1;
                        state_d    = StPayload;
                    end
                end
                StPayload: begin
                    if (bus.din_vld) begin
                        if (bus.din == EP_BYTE && zcnt == 2'd2) begin
                            drop = 1'b1;
                            if (ep_cnt_q != '1) begin
                                ep_cnt_d = ep_cnt_q + 1'b1;
                            end
                        end else if (bus.din == 8'h00 && zcnt == 2'd2) begin
                            discard   = 1'b1;
                            nal_end_d = 1'b1;
                            state_d   = StSearch;
                        end else begin
                            push = 1'b1;
                        end
                    end
                end
                StFlush: begin
                    // Entries beyond the trailing zero run are real payload.
                    if (win_cnt > zcnt) begin
                        pop = 1'b1;
                    end else begin
                        nal_end_d = 1'b1;
                        discard   = 1'b1;
                        state_d   = StSearch;
                    end
                end
                default: state_d = StSearch;
            endcase
        end

        // eos acts after any same-cycle byte has been processed.
        if (bus.eos) begin
            if (state_q == StPayload && state_d == StPayload) begin
                state_d = StFlush;
            end else if (!start_code && (state_q == StHdr0 || state_q == StHdr1)) begin
                state_d   = StSearch;
                hdr_vld_d = 1'b0;
            end
        end

        busy_d = (state_d == StFlush);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StSearch;
            hdr0_q      <= 8'h00;
            nal_type_q  <= 6'd0;
            layer_id_q  <= 6'd0;
            tid_q       <= 3'd0;
            hdr_err_q   <= 1'b0;
            hdr_vld_q   <= 1'b0;
            nal_start_q <= 1'b0;
            nal_end_q   <= 1'b0;
            busy_q      <= 1'b0;
            ep_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            hdr0_q      <= hdr0_d;
            nal_type_q  <= nal_type_d;
            layer_id_q  <= layer_id_d;
            tid_q       <= tid_d;
            hdr_err_q   <= hdr_err_d;
            hdr_vld_q   <= hdr_vld_d;
            nal_start_q <= nal_start_d;
            nal_end_q   <= nal_end_d;
            busy_q      <= busy_d;
            ep_cnt_q    <= ep_cnt_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.nal_start = nal_start_q;
    assign bus.hdr_vld   = hdr_vld_q;
    assign bus.nal_type  = nal_type_q;
    assign bus.layer_id  = layer_id_q;
    assign bus.tid_plus1 = tid_q;
    assign bus.hdr_err   = hdr_err_q;
    assign bus.nal_end   = nal_end_q;
    assign bus.ep_cnt    = ep_cnt_q;
endmodule

// File: tb/tb_nal_unit_parser.sv
// Self-checking bench for nal_unit_parser: a stream-level Annex-B model builds
// the expected RBSP bytes, headers and NAL closings; a monitor checks each cycle.
module tb_nal_unit_parser;
    import hevc_nal_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    nal_unit_parser_if #(.EP_CNT_W(16)) bus ();

    nal_unit_parser #(.EP_CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad = 0;

    logic [7:0]  exp_rbsp[$];
    logic [7:0]  obs_rbsp[$];
    logic [15:0] exp_hdr[$];   // {nal_type, layer_id, tid_plus1, hdr_err}
    logic [15:0] exp_end[$];   // ep_cnt expected when each NAL closes
    int          exp_start = 0;
    int          obs_start = 0;
    bit          busy_seen = 1'b0;
    logic [15:0] ep_prev = 16'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Stream-level model: split on start codes, close on 00 00 00 / 00 00 01,
    // strip 03 after two zeros, drop trailing zeros at eos; an unterminated NAL
    // (no eos) leaves its last two payload bytes unemitted.
    task automatic model(input logic [7:0] s[$], input bit with_eos);
        int sc[$];
        for (int p = 2; p < s.size(); p++) begin
            if (s[p] == 8'h01 && s[p-1] == 8'h00 && s[p-2] == 8'h00) sc.push_back(p);
        end
        for (int k = 0; k < sc.size(); k++) begin
            int         p;
            int         e;
            bit         closed;
            int         zc;
            int         ep;
            logic [7:0] b0;
            logic [7:0] b1;
            logic [7:0] raw[$];
            logic [7:0] pl[$];
            p = sc[k];
            e = s.size();
            closed = 1'b0;
            zc = 0;
            ep = 0;
            for (int j = p + 1; j + 2 < s.size(); j++) begin
                if (!closed && s[j] == 8'h00 && s[j+1] == 8'h00 &&
                    (s[j+2] == 8'h00 || s[j+2] == 8'h01)) begin
                    e = j;
                    closed = 1'b1;
                end
            end
            for (int j = p + 1; j < e; j++) raw.push_back(s[j]);
            exp_start++;
            if (raw.size() < 2) continue;
            b0 = raw[0];
            b1 = raw[1];
            exp_hdr.push_back({b0[6:1], b0[0], b1[7:3], b1[2:0],
                               b0[7] | (b1[2:0] == 3'd0)});
            for (int j = 0; j < raw.size(); j++) begin
                if (j >= 2 && raw[j] == EP_BYTE && zc >= 2) begin
                    ep++;
                    zc = 0;
                end else begin
                    if (j >= 2) pl.push_back(raw[j]);
                    zc = (raw[j] == 8'h00) ? zc + 1 : 0;
                end
            end
            if (closed) begin
                exp_end.push_back(16'(ep));
            end else if (with_eos) begin
                while (zc > 0 && pl.size() > 0) begin
                    void'(pl.pop_back());
                    zc--;
                end
                exp_end.push_back(16'(ep));
            end else begin
                repeat (2) if (pl.size() > 0) void'(pl.pop_back());
            end
            foreach (pl[i]) exp_rbsp.push_back(pl[i]);
        end
    endtask

    // Per-cycle compare against the model's expectations.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rbsp_vld) begin
                obs_rbsp.push_back(bus.rbsp_byte);
                chk("rbsp_expected", 32'(exp_rbsp.size() > 0), 32'd1);
                if (exp_rbsp.size() > 0) chk("rbsp_byte", 32'(bus.rbsp_byte),
                                             32'(exp_rbsp.pop_front()));
            end
            if (bus.hdr_vld) begin
                chk("hdr_expected", 32'(exp_hdr.size() > 0), 32'd1);
                if (exp_hdr.size() > 0)
                    chk("hdr_fields", 32'({bus.nal_type, bus.layer_id, bus.tid_plus1,
                                           bus.hdr_err}), 32'(exp_hdr.pop_front()));
            end
            if (bus.nal_start) begin
                obs_start++;
                chk("ep_cnt_at_start", 32'(bus.ep_cnt), 32'd0);
            end
            if (bus.nal_end) begin
                chk("nal_end_expected", 32'(exp_end.size() > 0), 32'd1);
                if (exp_end.size() > 0) chk("ep_cnt_at_end", 32'(ep_prev),
                                            32'(exp_end.pop_front()));
                chk("busy_at_end", 32'(bus.busy), 32'd0);
            end
            if (bus.busy) busy_seen = 1'b1;
            ep_prev = bus.ep_cnt;
        end
    end

    task automatic chk_reset_outputs(input string name);
        chk(name, 32'({bus.busy, bus.rbsp_vld, bus.nal_start, bus.hdr_vld, bus.nal_end,
                       bus.hdr_err, bus.tid_plus1, bus.nal_type, bus.layer_id,
                       bus.rbsp_byte}), 32'd0);
        chk({name, "_ep"}, 32'(bus.ep_cnt), 32'd0);
    endtask

    task automatic clear_model();
        exp_rbsp.delete();
        obs_rbsp.delete();
        exp_hdr.delete();
        exp_end.delete();
        exp_start = 0;
        obs_start = 0;
        busy_seen = 1'b0;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_model();
        @(negedge clk);
        chk_reset_outputs("reset_state");
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] s[$], input bit loader);
        for (int i = 0; i < s.size(); i++) begin
            bus.din = s[i];
            bus.din_vld = 1'b1;
            @(posedge clk);
            #1;
            bus.din_vld = 1'b0;
            if (loader && (i % 2 == 1)) begin
                repeat (6) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic pulse_eos();
        bus.eos = 1'b1;
        @(posedge clk);
        #1;
        bus.eos = 1'b0;
    endtask

    task automatic drain(input string name);
        repeat (12) @(posedge clk);
        #1;
        chk({name, "_rbsp_left"}, 32'(exp_rbsp.size()), 32'd0);
        chk({name, "_hdr_left"}, 32'(exp_hdr.size()), 32'd0);
        chk({name, "_end_left"}, 32'(exp_end.size()), 32'd0);
        chk({name, "_starts"}, 32'(obs_start), 32'(exp_start));
        chk({name, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic chk_obs(input string name, input logic [7:0] want[$]);
        chk({name, "_len"}, 32'(obs_rbsp.size()), 32'(want.size()));
        for (int i = 0; i < want.size() && i < obs_rbsp.size(); i++)
            chk(name, 32'(obs_rbsp[i]), 32'(want[i]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] s1[$];
        logic [7:0] s2[$];
        logic [7:0] s3[$];
        logic [7:0] s4[$];
        logic [7:0] s6a[$];
        logic [7:0] s6b[$];
        logic [7:0] w[$];
        logic [15:0] h;

        bus.din = 8'h00;
        bus.din_vld = 1'b0;
        bus.eos = 1'b0;
        s1  = '{8'h00, 8'h00, 8'h01, 8'h40, 8'h01, 8'h0C, 8'h01, 8'hFF};
        s2  = '{8'h00, 8'h00, 8'h01, 8'h26, 8'h01, 8'hAF, 8'h00, 8'h00, 8'h03,
                8'h01, 8'h55};
        s3  = '{8'h00, 8'h00, 8'h01, 8'h02, 8'h01, 8'hAB, 8'hCD, 8'h00, 8'h00,
                8'h00, 8'h01, 8'h02, 8'h01};
        s4  = '{8'h00, 8'h00, 8'h01, 8'hC0, 8'h00};
        s6a = '{8'h00, 8'h00, 8'h01, 8'h26, 8'h01, 8'hAF};
        s6b = '{8'h00, 8'h00, 8'h01, 8'h40, 8'h01};

        // 1: VPS header, short payload, eos flush.
        reset_dut();
        model(s1, 1'b1);
        chk("model_t1_len", 32'(exp_rbsp.size()), 32'd3);
        h = exp_hdr[0];
        chk("model_t1_hdr", 32'(h), 32'({NAL_VPS, 6'd0, 3'd1, 1'b0}));
        send(s1, 1'b0);
        pulse_eos();
        drain("t1");
        chk("t1_busy_seen", 32'(busy_seen), 32'd1);
        w = '{8'h0C, 8'h01, 8'hFF};
        chk_obs("t1_rbsp", w);

        // 2: emulation-prevention byte removed, 00 00 01 inside RBSP kept.
        reset_dut();
        model(s2, 1'b1);
        chk("model_t2_ep", 32'(exp_end[0]), 32'd1);
        h = exp_hdr[0];
        chk("model_t2_type", 32'(h[15:10]), 32'd19);
        send(s2, 1'b0);
        pulse_eos();
        drain("t2");
        w = '{8'hAF, 8'h00, 8'h00, 8'h01, 8'h55};
        chk_obs("t2_rbsp", w);

        // 3: trailing zeros before a 4-byte start code are dropped.
        reset_dut();
        model(s3, 1'b0);
        chk("model_t3_starts", 32'(exp_start), 32'd2);
        send(s3, 1'b0);
        drain("t3");
        w = '{8'hAB, 8'hCD};
        chk_obs("t3_rbsp", w);

        // 4: forbidden bit and tid_plus1=0 flag a header error.
        reset_dut();
        model(s4, 1'b0);
        h = exp_hdr[0];
        chk("model_t4_hdr", 32'(h), 32'({6'd32, 6'd0, 3'd0, 1'b1}));
        send(s4, 1'b0);
        drain("t4");

        // 5: test 1 with the 2-on/6-off loader pattern.
        reset_dut();
        model(s1, 1'b1);
        send(s1, 1'b1);
        pulse_eos();
        drain("t5");
        chk("t5_busy_seen", 32'(busy_seen), 32'd1);
        w = '{8'h0C, 8'h01, 8'hFF};
        chk_obs("t5_rbsp", w);

        // 6: reset mid-NAL discards it without nal_end; next NAL decodes cleanly.
        reset_dut();
        model(s6a, 1'b0);
        send(s6a, 1'b0);
        drain("t6a");
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_model();
        @(negedge clk);
        chk_reset_outputs("t6_mid_reset");
        @(posedge clk);
        #1;
        model(s6b, 1'b1);
        send(s6b, 1'b0);
        pulse_eos();
        drain("t6b");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
